// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
// Latency: n/a (definitions only).
// Backpressure: n/a. Consumers use MULDIV_DIVZERO_EN to enable the zero-divisor bypass.
package muldiv_pkg;

   // Pipeline op encodings
   localparam logic [2:0] OP_MULTU = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   // Unit function encodings (equal to op[1:0] of a mul/div op)
   localparam logic [1:0] FN_MULTU = 2'd0;
   localparam logic [1:0] FN_MULT  = 2'd1;
   localparam logic [1:0] FN_DIVU  = 2'd2;
   localparam logic [1:0] FN_DIV   = 2'd3;

   // Controller FSM state
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;

   // LO value written by the zero-divisor bypass
   localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_hilo.sv
// HI/LO architectural registers with their write-source mux.
// Latency: writes land on the next rising edge; hi/lo are direct register outputs.
// Backpressure: none; the controller guarantees at most one write source per cycle.
module muldiv_hilo
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        mt_hi,
   input  logic        mt_lo,
   input  logic [31:0] mt_data,
   input  logic        unit_we,
   input  logic [31:0] unit_hi,
   input  logic [31:0] unit_lo,
   input  logic        dz_we,
   input  logic [31:0] dz_a,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // Unit result has priority, then zero-divisor bypass, then MTHI/MTLO moves
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (unit_we) begin
         hi <= unit_hi;
         lo <= unit_lo;
      end else if (dz_we) begin
         hi <= dz_a;
         lo <= DZ_LO;
      end else begin
         if (mt_hi) hi <= mt_data;
         if (mt_lo) lo <= mt_data;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences mul/div ops onto an external unit and owns HI/LO (MULDIV_DIVZERO_EN: zero-divisor bypass).
// Latency: mul/div occupies START plus >=1 WAIT cycle; MFHI/MFLO read same cycle; MTHI/MTLO next edge.
// Backpressure: stall = op_valid while not IDLE; the pipeline holds op/a/b until stall drops.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic [1:0]  md_func,
   output logic        md_start,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_busy,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo
);

   state_t      state;
   logic        discard;
   logic        idle;
   logic        take;
   logic        is_md;
   logic        div_zero;
   logic        start_md;
   logic        dz_we;
   logic        mt_hi;
   logic        mt_lo;
   logic        done;
   logic        unit_we;
   logic [31:0] hi;
   logic [31:0] lo;

   assign idle  = (state == ST_IDLE);
   // A flush in IDLE kills whatever op the pipeline presents this cycle.
   assign take  = op_valid && idle && !flush;
   assign is_md = !op[2];

`ifdef MULDIV_DIVZERO_EN
   assign div_zero = ((op[1:0] == FN_DIVU) || (op[1:0] == FN_DIV)) && (b == '0);
`else
   assign div_zero = 1'b0;
`endif

   assign start_md = take && is_md && !div_zero;
   assign dz_we    = take && is_md && div_zero;
   assign mt_hi    = take && (op == OP_MTHI);
   assign mt_lo    = take && (op == OP_MTLO);
   assign done     = (state == ST_WAIT) && !md_busy;
   // A flush on the completion cycle also kills the in-flight result.
   assign unit_we  = done && !discard && !flush;

   assign stall = op_valid && !idle;

   // Same-cycle HI/LO readback; zero whenever no readback is being accepted
   always_comb begin
      rdata = '0;
      if (op_valid && idle) begin
         if (op == OP_MFHI)      rdata = hi;
         else if (op == OP_MFLO) rdata = lo;
      end
   end

   // Controller FSM: operand capture, one-cycle start pulse, completion wait, discard tracking
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         md_start <= 1'b0;
         md_a     <= '0;
         md_b     <= '0;
         md_func  <= '0;
         discard  <= 1'b0;
      end else begin
         md_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_md) begin
                  state    <= ST_START;
                  md_start <= 1'b1;
                  md_a     <= a;
                  md_b     <= b;
                  md_func  <= op[1:0];
               end
            end
            ST_START: begin
               state <= ST_WAIT;
               if (flush) discard <= 1'b1;
            end
            ST_WAIT: begin
               if (flush) discard <= 1'b1;
               if (!md_busy) begin
                  state   <= ST_IDLE;
                  discard <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   muldiv_hilo u_hilo (
      .clk     (clk),
      .resetn  (resetn),
      .mt_hi   (mt_hi),
      .mt_lo   (mt_lo),
      .mt_data (a),
      .unit_we (unit_we),
      .unit_hi (md_hi),
      .unit_lo (md_lo),
      .dz_we   (dz_we),
      .dz_a    (a),
      .hi      (hi),
      .lo      (lo)
   );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural mul/div unit (busy for 4 cycles after start).
// Latency: inputs change on the falling edge; outputs are sampled 1 time unit later.
// Backpressure: ops are held while stall is high, as the pipeline would.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        stall;
   logic [31:0] rdata;
   logic [1:0]  md_func;
   logic        md_start;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_busy;
   logic [31:0] md_hi = '0;
   logic [31:0] md_lo = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;
   int busy_cnt = 0;
   logic [31:0] st_a = '0;
   logic [31:0] st_b = '0;
   logic [1:0]  st_func = '0;
   logic signed [63:0] sx, sy;

   muldiv_ctrl dut (
      .clk      (clk),
      .resetn   (resetn),
      .op_valid (op_valid),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .stall    (stall),
      .rdata    (rdata),
      .md_func  (md_func),
      .md_start (md_start),
      .md_a     (md_a),
      .md_b     (md_b),
      .md_busy  (md_busy),
      .md_hi    (md_hi),
      .md_lo    (md_lo)
   );

   always #5 clk = ~clk;

   assign md_busy = (busy_cnt != 0);

   // Behavioural unit: latches operands on md_start, stays busy 4 cycles, result ready immediately
   always @(negedge clk) begin
      if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
      if (md_start) begin
         n_start  = n_start + 1;
         busy_cnt = 4;
         st_a     = md_a;
         st_b     = md_b;
         st_func  = md_func;
         case (md_func)
            FN_MULTU: {md_hi, md_lo} = {32'd0, md_a} * {32'd0, md_b};
            FN_MULT: begin
               sx = $signed(md_a);
               sy = $signed(md_b);
               {md_hi, md_lo} = sx * sy;
            end
            FN_DIVU: begin
               if (md_b == 0) begin md_hi = md_a; md_lo = 32'hFFFF_FFFF; end
               else begin md_lo = md_a / md_b; md_hi = md_a % md_b; end
            end
            default: begin
               if (md_b == 0) begin md_hi = md_a; md_lo = 32'hFFFF_FFFF; end
               else begin
                  md_lo = $signed(md_a) / $signed(md_b);
                  md_hi = $signed(md_a) % $signed(md_b);
               end
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present an op on the falling edge and hold it until stall drops; returns cycles stalled
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int stalls);
      @(negedge clk);
      op_valid = 1'b1; op = o; a = x; b = y; flush = 1'b0;
      #1;
      stalls = 0;
      while (stall && stalls < 40) begin
         stalls = stalls + 1;
         @(negedge clk);
         #1;
      end
      if (stall) chk("stall_timeout", 32'(stall), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got running, expected done)");
      $fatal(1);
   end

   initial begin
      int s;
      int n0;

      // Reset state, with a readback presented during reset
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      op_valid = 1'b1; op = OP_MFHI;
      #1;
      chk("rst_stall",    32'(stall),    32'd0);
      chk("rst_md_start", 32'(md_start), 32'd0);
      chk("rst_md_a",     md_a,          32'd0);
      chk("rst_md_b",     md_b,          32'd0);
      chk("rst_md_func",  32'(md_func),  32'd0);
      chk("rst_rdata",    rdata,         32'd0);
      @(negedge clk);
      resetn = 1'b1; op_valid = 1'b0;

      // MTHI then MFHI, MTLO then MFLO
      run_op(OP_MTHI, 32'h1234, 32'd0, s);
      chk("mthi_stall", 32'(s), 32'd0);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("mfhi_stall", 32'(s), 32'd0);
      chk("mfhi_rdata", rdata, 32'h1234);
      run_op(OP_MTLO, 32'hAAAA_5555, 32'd0, s);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("mflo_rdata", rdata, 32'hAAAA_5555);

      // MULTU 3*5 with a following MFLO that must stall until completion
      n0 = n_start;
      run_op(OP_MULTU, 32'd3, 32'd5, s);
      chk("multu_accept", 32'(s), 32'd0);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("multu_stall_cycles", 32'(s), 32'd5);
      chk("multu_lo", rdata, 32'd15);
      chk("multu_starts", 32'(n_start - n0), 32'd1);
      chk("multu_md_a", st_a, 32'd3);
      chk("multu_md_b", st_b, 32'd5);
      chk("multu_md_func", 32'(st_func), 32'(FN_MULTU));
      chk("multu_md_a_hold", md_a, 32'd3);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("multu_hi", rdata, 32'd0);

      // DIVU 100/7
      run_op(OP_DIVU, 32'd100, 32'd7, s);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("divu_lo", rdata, 32'd14);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("divu_hi", rdata, 32'd2);

      // MULT arriving behind DIVU stalls through the completion cycle
      run_op(OP_DIVU, 32'd17, 32'd5, s);
      run_op(OP_MULT, 32'hFFFF_FFFC, 32'd5, s);
      chk("mult_behind_stall", 32'(s), 32'd5);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("mult_lo", rdata, 32'hFFFF_FFEC);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("mult_hi", rdata, 32'hFFFF_FFFF);

      // DIV -7/2 flushed in WAIT: HI/LO keep prior values
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, s);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("div_md_func", 32'(md_func), 32'(FN_DIV));
      chk("div_md_start", 32'(md_start), 32'd1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("flush_lo", rdata, 32'hFFFF_FFEC);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("flush_hi", rdata, 32'hFFFF_FFFF);

      // Flush in IDLE blocks an MTHI
      @(negedge clk);
      op_valid = 1'b1; op = OP_MTHI; a = 32'hDEAD; flush = 1'b1;
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("idle_flush_hi", rdata, 32'hFFFF_FFFF);

      // DIVU by zero
      n0 = n_start;
      run_op(OP_DIVU, 32'd9, 32'd0, s);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
`ifdef MULDIV_DIVZERO_EN
      chk("dz_starts", 32'(n_start - n0), 32'd0);
      chk("dz_stall", 32'(s), 32'd0);
`else
      chk("dz_starts", 32'(n_start - n0), 32'd1);
      chk("dz_stall", 32'(s), 32'd5);
`endif
      chk("dz_hi", rdata, 32'd9);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("dz_lo", rdata, 32'hFFFF_FFFF);

      // Reset during WAIT, then MULT 2*3
      run_op(OP_MULTU, 32'd7, 32'd7, s);
      @(negedge clk);
      op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0; op_valid = 1'b1; op = OP_MFLO;
      #1;
      chk("wrst_stall",    32'(stall),    32'd0);
      chk("wrst_md_start", 32'(md_start), 32'd0);
      chk("wrst_md_a",     md_a,          32'd0);
      chk("wrst_md_b",     md_b,          32'd0);
      chk("wrst_rdata",    rdata,         32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1; op_valid = 1'b0;
      run_op(OP_MULT, 32'd2, 32'd3, s);
      run_op(OP_MFLO, 32'd0, 32'd0, s);
      chk("post_rst_lo", rdata, 32'd6);
      chk("post_rst_stall", 32'(s), 32'd5);
      run_op(OP_MFHI, 32'd0, 32'd0, s);
      chk("post_rst_hi", rdata, 32'd0);

      @(negedge clk);
      op_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 op_valid  input  1  pipeline presents an op this cycle.
REQ-005 op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-006 a, b  input  32 each  rs and rt operands.
REQ-007 flush  input  1  pipeline kill; the in-flight result is discarded.
REQ-008 stall  output  1  op not accepted this cycle; the pipeline holds op, a and b.
REQ-009 rdata  output  32  HI or LO readback for MFHI or MFLO.
REQ-010 md_func  output  2  unit function; SHALL equal op[1:0] of the accepted op.
REQ-011 md_start, md_a, md_b  output  1/32/32  unit start pulse and registered operands.
REQ-012 md_busy, md_hi, md_lo  input  1/32/32  unit busy flag and result.

Function
REQ-013 The FSM SHALL have three states: IDLE, START and WAIT.
REQ-014 IDLE to START: the block SHALL take this transition on op_valid with op<4 and no stall; it SHALL latch a, b and op[1:0] into md_a, md_b and md_func.
REQ-015 In START, md_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT.
REQ-016 In WAIT, when md_busy=0, the block SHALL write md_hi to HI and md_lo to LO on that edge (unless discard is set) and return to IDLE.
REQ-017 Minimum mul/div occupancy SHALL be 2 cycles (START plus one WAIT cycle) before IDLE.
REQ-018 md_a, md_b and md_func SHALL hold stable from START until the block returns to IDLE.
REQ-019 stall SHALL be combinational: op_valid AND state!=IDLE, for any op.
REQ-020 In IDLE, MFHI or MFLO SHALL give rdata=HI or LO in the same cycle with no stall; otherwise rdata=0.
REQ-021 In IDLE, MTHI or MTLO SHALL write a to HI or LO on the next edge.
REQ-022 flush in START or WAIT SHALL set discard; the sequence SHALL still run to completion without writing HI/LO; discard SHALL clear on the return to IDLE.
REQ-023 flush in IDLE SHALL block acceptance of an op in that same cycle.
REQ-024 A new mul/div op arriving on the completion cycle SHALL stall; it SHALL be accepted on the following IDLE cycle.

Reset
REQ-025 When resetn=0, the block SHALL force: state=IDLE, HI=0, LO=0, md_start=0, md_a=0, md_b=0, md_func=0, discard=0.
REQ-026 Reset mid-operation SHALL abandon the operation; the stale md_busy SHALL be ignored because the state is IDLE.

Configuration
REQ-027 Macro MULDIV_DIVZERO_EN:
- Defined: DIVU or DIV with b=0 SHALL NOT pulse md_start; the block SHALL go IDLE to WAIT-bypass and back to IDLE in one cycle, writing HI=a and LO=32'hFFFFFFFF.
- Undefined: a zero divisor SHALL run through the unit normally.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encodings, the md_func encodings (MULTU=0, MULT=1, DIVU=2, DIV=3) and the FSM state typedef.
REQ-029 HI/LO storage, with its write mux, SHALL be sub-module muldiv_hilo; the FSM SHALL stay in muldiv_ctrl.

Verification
REQ-030 MTHI a=32'h1234 then MFHI: rdata=32'h1234; no stall.
REQ-031 MULTU a=3, b=5 with a model unit busy for 4 cycles: md_start pulses once; stall holds for a following MFLO; then HI=0 and LO=15.
REQ-032 DIV a=-7, b=2, followed by flush in WAIT: HI/LO keep their prior values; the next MFLO returns the old LO.
REQ-033 MULDIV_DIVZERO_EN defined, DIVU a=9, b=0: no md_start; one cycle later HI=9 and LO=32'hFFFFFFFF.
REQ-034 resetn pulsed low during WAIT: all outputs return to reset values; a following MULT 2*3 completes with LO=6.
